// File: rtl/pixel_line_rx.sv
// Receive-side framer for the rotated pixel stream: geometry check, FWFT FIFO,
// and re-emission with counter-derived sof/eol/eof markers.
module pixel_line_rx #(
  parameter int LINE_LEN   = 256,
  parameter int NUM_LINES  = 256,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_eol,
  input  logic              in_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              overflow,
  output logic              frame_err,
  output logic              frame_done,
  output logic [7:0]        line_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [7:0] COL_LAST = 8'(LINE_LEN - 1);
  localparam logic [7:0] ROW_LAST = 8'(NUM_LINES - 1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eol;
    logic              eof;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [1:0]    state;
  logic [7:0]    col, row, col_cur, row_cur;
  logic          beat_rx, eol_gen, eof_gen, mismatch, full, push, pop, first;

  // The first beat of a frame is treated as (0,0) regardless of stale counters.
  assign first    = (state == IDLE);
  assign col_cur  = first ? 8'd0 : col;
  assign row_cur  = first ? 8'd0 : row;
  assign eol_gen  = (col_cur == COL_LAST);
  assign eof_gen  = eol_gen && (row_cur == ROW_LAST);
  assign mismatch = (in_eol != eol_gen) || (in_eof != eof_gen);

  assign beat_rx    = in_valid && (state == IDLE || state == RECV);
  assign full       = (count == CNT_FULL);
  assign push       = beat_rx && !full;
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      line_cnt  <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // Dropped beats still advance the counters so geometry stays aligned.
      if (beat_rx) begin
        overflow  <= (!first && overflow) || full;
        frame_err <= (!first && frame_err) || mismatch;
        if (eol_gen) begin
          col      <= '0;
          row      <= row_cur + 8'd1;
          line_cnt <= (first ? 8'd0 : line_cnt) + 8'd1;
        end else begin
          col <= col_cur + 8'd1;
          row <= row_cur;
          if (first) line_cnt <= '0;
        end
      end else if (in_valid && state == DRAIN) begin
        frame_err <= 1'b1;
      end

      case (state)
        IDLE, RECV: if (beat_rx) state <= eof_gen ? DRAIN : RECV;
        DRAIN:      if (count_next == '0) state <= DONE;
        default:    state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: in_data, sof: first, eol: eol_gen, eof: eof_gen};
  end

  assign head       = mem[rd_ptr];
  assign out_data   = out_valid ? head.data : '0;
  assign out_sof    = out_valid && head.sof;
  assign out_eol    = out_valid && head.eol;
  assign out_eof    = out_valid && head.eof;
  assign frame_done = (state == DONE);
endmodule

// File: tb/tb_pixel_line_rx.sv
// Bench for pixel_line_rx on a 4x4 frame with a 4-entry FIFO: scoreboard model
// checked every cycle, plus a vector table and directed corner sequences.
module tb_pixel_line_rx;
  localparam int LL = 4, NL = 4, DW = 24, FD = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_eol = 1'b0, in_eof = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_sof, out_eol, out_eof, overflow, frame_err, frame_done;
  logic [DW-1:0] out_data;
  logic [7:0]    line_cnt;

  pixel_line_rx #(.LINE_LEN(LL), .NUM_LINES(NL), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_eol(in_eol),
    .in_eof(in_eof), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .overflow(overflow),
    .frame_err(frame_err), .frame_done(frame_done), .line_cnt(line_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s, e, f;
  } pix_t;

  typedef struct {
    logic [DW-1:0] d;
    bit ie, ief, es, ee, ef;
  } vec_t;

  int tests = 0, fails = 0, ndone = 0;
  pix_t q[$], outlog[$];

  // Reference model state: 0 idle, 1 recv, 2 drain, 3 done.
  int mstate = 0, mcol = 0, mrow = 0, mcount = 0, mline = 0;
  bit mov = 0, merr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  int   ps, ns;
  bit   pushf, popf, eg, fg;
  pix_t got, exp_p;
  always @(negedge clk) begin
    if (rst) begin
      mstate = 0; mcol = 0; mrow = 0; mcount = 0; mline = 0; mov = 0; merr = 0;
      q.delete();
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, mcount > 0});
      chk("frame_done", {31'd0, frame_done}, {31'd0, mstate == 3});
      chk("overflow", {31'd0, overflow}, {31'd0, mov});
      chk("frame_err", {31'd0, frame_err}, {31'd0, merr});
      chk("line_cnt", {24'd0, line_cnt}, 32'(mline & 8'hff));
      if (frame_done) ndone++;
      popf = (mcount > 0) && out_ready;
      if (popf) begin
        got = '{out_data, out_sof, out_eol, out_eof};
        outlog.push_back(got);
        if (q.size() == 0) chk("pop_unexpected", 32'(got), 32'hffff_ffff);
        else begin
          exp_p = q.pop_front();
          chk("pixel", 32'(got), 32'(exp_p));
        end
      end
      ps = mstate; ns = ps; pushf = 0;
      if (in_valid) begin
        if (ps == 0 || ps == 1) begin
          if (ps == 0) begin mcol = 0; mrow = 0; mline = 0; mov = 0; merr = 0; end
          eg = (mcol == LL - 1);
          fg = eg && (mrow == NL - 1);
          if (in_eol != eg || in_eof != fg) merr = 1;
          if (mcount < FD) begin
            pushf = 1;
            q.push_back('{in_data, ps == 0, eg, fg});
          end else mov = 1;
          if (eg) begin mcol = 0; mrow++; mline++; end else mcol++;
          ns = fg ? 2 : 1;
        end else if (ps == 2) merr = 1;
      end
      mcount = mcount + int'(pushf) - int'(popf);
      if (ps == 3) ns = 0;
      else if (ps == 2 && mcount == 0) ns = 3;
      mstate = ns;
    end
  end

  task automatic beat(input logic [DW-1:0] d, input bit e, input bit f);
    in_valid = 1'b1; in_data = d; in_eol = e; in_eof = f;
    @(posedge clk); #1;
    in_valid = 1'b0; in_eol = 1'b0; in_eof = 1'b0;
  endtask

  task automatic good_beat();
    int c, r;
    c = (mstate == 0) ? 0 : mcol;
    r = (mstate == 0) ? 0 : mrow;
    beat(DW'(r * 4 + c), c == LL - 1, (c == LL - 1) && (r == NL - 1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic finish_frame();
    int k = 0;
    while (mstate == 1 && k < 300) begin good_beat(); k++; end
    chk("finish_frame_bound", {31'd0, k < 300}, 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!(mstate == 0 && mcount == 0) && k < 100) begin idle(1); k++; end
    chk("drain_bound", {31'd0, k < 100}, 32'd1);
  endtask

  vec_t tbl[16];
  int   d0;

  initial begin
    for (int i = 0; i < 16; i++)
      tbl[i] = '{DW'(i), (i % 4) == 3, i == 15, i == 0, (i % 4) == 3, i == 15};

    idle(2);
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_markers", {29'd0, out_sof, out_eol, out_eof}, 32'd0);
    chk("rst_flags", {29'd0, overflow, frame_err, frame_done}, 32'd0);
    chk("rst_line_cnt", {24'd0, line_cnt}, 32'd0);

    // Clean full frame from the vector table.
    outlog.delete(); out_ready = 1'b1; d0 = ndone;
    for (int i = 0; i < 16; i++) beat(tbl[i].d, tbl[i].ie, tbl[i].ief);
    wait_done();
    chk("t1_count", outlog.size(), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < outlog.size())
        chk($sformatf("t1_pix%0d", i), 32'(outlog[i]), 32'({tbl[i].d, tbl[i].es, tbl[i].ee, tbl[i].ef}));
    chk("t1_done_once", ndone - d0, 32'd1);
    chk("t1_line_cnt", {24'd0, line_cnt}, 32'd4);
    chk("t1_frame_err", {31'd0, frame_err}, 32'd0);

    // Backpressure: six beats into a 4-deep FIFO, beats 4 and 5 dropped.
    out_ready = 1'b0;
    repeat (6) good_beat();
    chk("t2_overflow", {31'd0, overflow}, 32'd1);
    outlog.delete(); out_ready = 1'b1;
    idle(6);
    chk("t2_kept", outlog.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < outlog.size()) chk($sformatf("t2_data%0d", i), 32'(outlog[i].d), i);
    repeat (2) good_beat();
    idle(3);
    chk("t2_after", outlog.size(), 32'd6);
    if (outlog.size() == 6) chk("t2_eol_col3", {31'd0, outlog[5].e}, 32'd1);
    finish_frame(); wait_done();

    // Marker error: in_eol at col 2.
    outlog.delete();
    beat(0, 0, 0); beat(1, 0, 0); beat(2, 1, 0);
    chk("t3_err_set", {31'd0, frame_err}, 32'd1);
    finish_frame(); wait_done();
    chk("t3_err_sticky", {31'd0, frame_err}, 32'd1);
    chk("t3_count", outlog.size(), 32'd16);
    if (outlog.size() == 16) chk("t3_eol_c2_c3", {30'd0, outlog[2].e, outlog[3].e}, 32'd1);

    // Full FIFO: push and pop in the same cycle -> push rejected.
    out_ready = 1'b0;
    repeat (4) good_beat();
    outlog.delete(); out_ready = 1'b1;
    good_beat();
    chk("t4_overflow", {31'd0, overflow}, 32'd1);
    idle(5);
    chk("t4_drained", outlog.size(), 32'd4);
    finish_frame(); wait_done();

    // Reset mid-frame with entries buffered.
    out_ready = 1'b0;
    repeat (7) good_beat();
    #2 rst = 1'b1;
    #1 chk("t5_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t5_flags_clr", {30'd0, overflow, frame_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    outlog.delete(); out_ready = 1'b1;
    repeat (16) good_beat();
    wait_done();
    chk("t5_count", outlog.size(), 32'd16);
    if (outlog.size() > 1) chk("t5_sof", {30'd0, outlog[0].s, outlog[1].s}, 32'd2);
    chk("t5_flags", {30'd0, overflow, frame_err}, 32'd0);
    chk("t5_line_cnt", {24'd0, line_cnt}, 32'd4);

    // Beat arriving while draining.
    outlog.delete(); out_ready = 1'b1; d0 = ndone;
    repeat (15) good_beat();
    out_ready = 1'b0;
    good_beat();
    beat(24'hABCDEF, 0, 0);
    chk("t6_err", {31'd0, frame_err}, 32'd1);
    out_ready = 1'b1;
    wait_done();
    chk("t6_done_once", ndone - d0, 32'd1);
    chk("t6_count", outlog.size(), 32'd16);
    if (outlog.size() == 16) chk("t6_last_eof", {31'd0, outlog[15].f}, 32'd1);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: run did not complete");
    $fatal(1);
  end
endmodule

// File: doc/pixel_line_rx.md
# pixel_line_rx

Receive-side framer for the rotated 256x256 RGB pixel stream that the rotation adapter emits during read-out. It sits between the adapter's read-out port and the downstream display/DMA consumer, and does four things. It accepts one pixel per qualified cycle with no input backpressure, checks line and frame structure against the configured geometry, buffers pixels in a small first-word-fall-through FIFO, and re-emits them on a valid/ready stream with start-of-frame, end-of-line and end-of-frame markers. It also reports overflow, framing errors and frame completion.

## Interface
- LINE_LEN, 256, pixels per line; power of two, 2..256
- NUM_LINES, 256, lines per frame; power of two, 2..256
- DATA_W, 24, pixel width (8-bit R,G,B)
- FIFO_DEPTH, 16, buffer entries; power of two, >= 4

- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input pixel qualifier
- in_data  in  DATA_W  input pixel
- in_eol  in  1  source end-of-line marker, sampled only with in_valid
- in_eof  in  1  source end-of-frame marker, sampled only with in_valid
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accept
- out_data  out  DATA_W  head pixel
- out_sof  out  1  head is pixel (0,0) of the frame
- out_eol  out  1  head is the last pixel of a line (col == LINE_LEN-1)
- out_eof  out  1  head is the last pixel of the frame
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full
- frame_err  out  1  sticky: marker mismatch detected
- frame_done  out  1  one-cycle pulse after the last frame pixel is popped
- line_cnt  out  8  lines fully received in the current frame

## Operation
- State machine IDLE -> RECV -> DRAIN -> DONE -> IDLE.
- IDLE:
  - The first in_valid beat moves the FSM to RECV.
  - On that same edge, overflow, frame_err and line_cnt clear, col/row start at 0, and the pixel is pushed with sof=1.
- RECV:
  - Each in_valid beat pushes {data, sof, eol_gen, eof_gen} when the FIFO is not full.
  - eol_gen = (col == LINE_LEN-1); eof_gen = eol_gen && (row == NUM_LINES-1).
  - Output markers come from the internal counters, never from in_eol/in_eof.
- Counters:
  - col increments on every in_valid beat and wraps to 0 after LINE_LEN-1.
  - On wrap, row increments and line_cnt increments.
  - Dropped pixels still advance the counters, so geometry stays aligned.
- Checks, evaluated per beat:
  - in_eol != eol_gen sets frame_err.
  - in_eof != eof_gen sets frame_err.
  - After a mismatch, counters are not resynchronised; the frame completes on the counted geometry.
- The beat with eof_gen=1 moves the FSM to DRAIN. In DRAIN, input beats are ignored: not pushed, not counted, and each one sets frame_err.
- DRAIN -> DONE when the FIFO is empty. DONE lasts exactly one cycle and drives frame_done=1, then returns to IDLE. line_cnt holds its value until the next frame starts.
- FIFO:
  - Pop occurs when out_valid && out_ready.
  - Push is allowed only when count < FIFO_DEPTH, evaluated on the pre-edge count.
  - When full, a push is rejected even if a pop happens in the same cycle; the dropped beat sets overflow.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
- Arithmetic: col, row and line_cnt are unsigned and wrap modulo 2^8. The FIFO count is $clog2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values:
  - state=IDLE; col=row=line_cnt=0.
  - out_valid=0; out_data, out_sof, out_eol and out_eof all 0.
  - overflow=0, frame_err=0, frame_done=0; FIFO empty.
- Latency: a pixel pushed at edge N into an empty FIFO appears at the head with out_valid=1 in the cycle after edge N. Throughput is 1 pixel/cycle.
- The output is held stable while out_valid && !out_ready.
- frame_done asserts the cycle after the edge that pops the eof pixel. It is high for exactly one cycle.
- Asynchronous reset mid-frame: all state clears immediately and the FIFO contents are discarded. The next in_valid beat is treated as (0,0).
- in_valid=0 cycles inside a line are legal; counters hold.

## Test plan
- Full frame, LINE_LEN=NUM_LINES=4, out_ready=1, in_data=row*4+col, correct markers -> 16 pixels out in order; sof only on pixel 0; eol on 3,7,11,15; eof on 15; frame_done one cycle after the eof pop; frame_err=0; line_cnt=4.
- Backpressure with FIFO_DEPTH=4 and out_ready=0 while 6 beats are sent -> entries 0..3 retained; overflow=1; beats 4,5 dropped; the next accepted pixel still gets eol=1 at col 3.
- Marker error: in_eol=1 asserted at col 2 -> frame_err=1 and stays set; the output eol still lands on col 3; frame completes after 16 beats.
- Full FIFO, push and pop in the same cycle with count=FIFO_DEPTH -> push rejected, overflow=1, count becomes FIFO_DEPTH-1.
- Reset asserted after 7 beats, then a clean frame -> out_valid drops immediately; the new frame's first pixel has sof=1; flags are 0 and line_cnt counts from 0.
- Beat during DRAIN (out_ready=0 after eof) -> not output, frame_err=1; frame_done fires once the FIFO is empty.
